// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit multiplexed seven-segment scanner.
// Segment patterns are active-low, ordered g..a on bits 6..0.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic       DP_OFF  = 1'b1;

    typedef logic [1:0] dig_idx_t;

    // Image shown on the display: four nibbles plus per-digit decimal point and blank
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    // Hex-to-segment table, entry 15 (F) first down to entry 0
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-update handshake: a write loads the shadow image, which goes live at the next frame boundary.
interface seg7_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_blank;

    modport master (output wr_valid, wr_data, wr_dp, wr_blank, input wr_ready);
    modport slave  (input wr_valid, wr_data, wr_dp, wr_blank, output wr_ready);
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot guard blanking, PWM brightness
// and a frame-synchronous double-buffered update port.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [3:0]            bright,
    seg7_scan_ctrl_if.slave       wr,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [3:0]            an,
    output logic                  frame_tick
);
    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_GUARD = PW'(GUARD);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);

    logic [PW-1:0] pre_q, pre_d;
    dig_idx_t      idx_q, idx_d;
    logic [3:0]    pwm_q, pwm_d;
    logic          pend_q, pend_d;
    disp_t         act_q, act_d;
    disp_t         shd_q, shd_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          wrap;
    logic          commit;
    logic          accept;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;

    assign nib = act_q.data[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib (nib),
        .seg (nib_seg)
    );

    always_comb begin
        wrap       = ena && (pre_q == PRE_MAX);
        commit     = wrap && (idx_q == 2'd3);
        accept     = wr.wr_valid && !pend_q;
        frame_tick = rst_n && commit;

        pre_d  = pre_q;
        idx_d  = idx_q;
        pwm_d  = pwm_q;
        pend_d = pend_q;
        act_d  = act_q;
        shd_d  = shd_q;

        if (ena) begin
            pwm_d = pwm_q + 4'd1;
            pre_d = wrap ? '0 : pre_q + PRE_ONE;
            if (wrap) idx_d = idx_q + 2'd1;
        end

        // Commit and accept are exclusive: accept needs pending clear, commit only acts when set
        if (commit && pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (accept) begin
            shd_d  = '{data: wr.wr_data, dp: wr.wr_dp, blank: wr.wr_blank};
            pend_d = 1'b1;
        end

        seg_d = nib_seg;
        dp_d  = ~act_q.dp[idx_q];
        an_d  = AN_OFF;
        if (ena && (pre_q >= PRE_GUARD) && (pwm_q <= bright) && !act_q.blank[idx_q])
            an_d = ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            idx_q  <= '0;
            pwm_q  <= '0;
            pend_q <= 1'b0;
            act_q  <= '0;
            shd_q  <= '0;
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            an_q   <= AN_OFF;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign wr.wr_ready = ~pend_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 16.
REQ-002 SHALL have parameter GUARD, default 64, meaning blanked cycles at the start of each slot (anti-ghosting); legal range 0 < GUARD < SCAN_DIV.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ena  in  1  high = scan runs; low = counters hold and all anodes off.
REQ-006 wr_valid  in  1  display-update request.
REQ-007 wr_ready  out  1  update accepted when wr_valid and wr_ready are both high on a clk edge.
REQ-008 wr_data  in  16  four hex nibbles; digit k = wr_data[4k+3:4k].
REQ-009 wr_dp  in  4  decimal point per digit, 1 = lit.
REQ-010 wr_blank  in  4  per-digit blank, 1 = digit dark.
REQ-011 bright  in  4  brightness; 15 = full, 0 = 1/16 duty.
REQ-012 seg  out  7  segments a..g on seg[0]..seg[6], active-low.
REQ-013 dp  out  1  decimal point, active-low.
REQ-014 an  out  4  digit anodes, active-low; an[k] drives digit k.
REQ-015 frame_tick  out  1  one-cycle pulse at every frame commit point.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 while ena=1, wrap to 0, and advance the 2-bit digit index (0,1,2,3,0...) on wrap.
REQ-017 A 4-bit PWM counter SHALL increment every cycle while ena=1, wrapping 15->0.
REQ-018 Digit k SHALL be driven (an[k]=0, others 1) only when index=k, prescaler >= GUARD, pwm <= bright, and active blank[k]=0; otherwise an=4'b1111.
REQ-019 seg SHALL be the hex decode of the active nibble of the current index (0->7'b1000000, 1->7'b1111001, F->7'b0001110, full 0-F table); dp SHALL equal ~active dp[index].
REQ-020 seg, dp, an SHALL be registered: one-cycle latency from counter state to pins.
REQ-021 Handshake: accepted write SHALL load a shadow register and set pending; wr_ready SHALL equal ~pending (registered).
REQ-022 Commit SHALL occur on the cycle the prescaler wraps with index=3: shadow copies to active, pending clears, frame_tick=1 for that cycle; without pending, frame_tick still pulses and active is unchanged.
REQ-023 While pending=1, wr_valid SHALL be ignored; a write cannot be accepted in the commit cycle (wr_ready is still 0), earliest acceptance is the following cycle.
REQ-024 wr_data, wr_dp, wr_blank SHALL be sampled only at acceptance; later changes have no effect.
REQ-025 ena low SHALL freeze prescaler, index, PWM and pending state, force an=4'b1111 (registered), suppress frame_tick; handshake acceptance continues.
REQ-026 bright is used live (no shadowing); a change takes effect on the next cycle.

Reset
REQ-027 While rst_n=0 at a clk edge: prescaler=0, index=0, pwm=0, pending=0, active and shadow registers=0, wr_ready=1, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
REQ-028 Reset mid-frame SHALL discard any pending update; first accepted write after reset commits at the first frame boundary.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16-entry hex-to-segment table, the active-low all-off constants, and the 2-bit digit index type.
REQ-030 Sub-module seg7_decode (combinational nibble -> 7-bit active-low segments) SHALL be instantiated once.

Verification (SCAN_DIV=16, GUARD=2)
REQ-031 Reset release, no writes, bright=15, ena=1 -> an cycles 1110,1101,1011,0111 every 16 cycles, off for 2 cycles per slot, seg=7'b1000000 throughout; frame_tick every 64 cycles.
REQ-032 Write wr_data=16'h1F3A, wr_dp=4'b0100 mid-frame -> wr_ready drops next cycle, display unchanged until frame_tick, then digits 0..3 show A,3,F,1 with dp low only on digit 2; wr_ready returns 1 the cycle after frame_tick.
REQ-033 Second write while pending -> ignored; value from first write displayed after commit.
REQ-034 bright=0 -> each anode low 1 cycle in 16 within unguarded slot region; bright=7 -> 8 in 16.
REQ-035 wr_blank=4'b1010 committed -> an[1], an[3] never low; ena=0 for 20 cycles -> an=1111, counters resume exactly where frozen.
REQ-036 rst_n low for 1 cycle with a write pending -> all outputs at reset values next cycle, pending update never appears.
